// File: rtl/display_scan_controller.sv
// Multiplexed scan controller for a common-anode seven-segment bank.
// Double-buffers hex data, blanks between digits, handles dp, blink and leading-zero suppression.
module display_scan_controller #(
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dpMask,
    input  logic [DIGITS-1:0]     blinkMask,
    input  logic                  blankZeros,
    input  logic                  load,
    output logic                  updated,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DigW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned FrW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CntW-1:0] CntLast  = CntW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] CntBlank = CntW'(BLANK_CYCLES);
    localparam logic [DigW-1:0] DigLast  = DigW'(DIGITS - 1);
    localparam logic [FrW-1:0]  FrLast   = FrW'(BLINK_FRAMES - 1);

    typedef enum logic [0:0] {StBlank, StDrive} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DigW-1:0]       digit_q, digit_d;
    logic [FrW-1:0]        frame_q, frame_d;
    logic                  phase_q, phase_d;
    logic [4*DIGITS-1:0]   act_val_q, act_val_d, pend_val_q, pend_val_d;
    logic [DIGITS-1:0]     act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic [DIGITS-1:0]     act_blink_q, act_blink_d, pend_blink_q, pend_blink_d;
    logic                  act_bz_q, act_bz_d, pend_bz_q, pend_bz_d;
    logic                  pend_valid_q, pend_valid_d;
    logic                  updated_q, updated_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [7:0]            seg_q, seg_d;
    logic                  wrap, boundary;

    function automatic logic [6:0] hex_pattern(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StBlank;
            cnt_q        <= '0;
            digit_q      <= '0;
            frame_q      <= '0;
            phase_q      <= 1'b0;
            act_val_q    <= '0;
            act_dp_q     <= '0;
            act_blink_q  <= '0;
            act_bz_q     <= 1'b0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_blink_q <= '0;
            pend_bz_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            updated_q    <= 1'b0;
            an_q         <= '1;
            seg_q        <= 8'hFF;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            frame_q      <= frame_d;
            phase_q      <= phase_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            act_blink_q  <= act_blink_d;
            act_bz_q     <= act_bz_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_blink_q <= pend_blink_d;
            pend_bz_q    <= pend_bz_d;
            pend_valid_q <= pend_valid_d;
            updated_q    <= updated_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    always_comb begin
        wrap     = (cnt_q == CntLast);
        boundary = wrap && (digit_q == DigLast);
        cnt_d    = wrap ? '0 : cnt_q + 1'b1;
        digit_d  = digit_q;
        if (wrap) begin
            digit_d = (digit_q == DigLast) ? '0 : digit_q + 1'b1;
        end

        state_d = state_q;
        unique case (state_q)
            StBlank: state_d = (cnt_d >= CntBlank) ? StDrive : StBlank;
            StDrive: if (wrap) state_d = (CntBlank == '0) ? StDrive : StBlank;
            default: state_d = StBlank;
        endcase

        frame_d = frame_q;
        phase_d = phase_q;
        if (boundary) begin
            if (frame_q == FrLast) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end

        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_blink_d = pend_blink_q;
        pend_bz_d    = pend_bz_q;
        pend_valid_d = pend_valid_q;
        act_val_d    = act_val_q;
        act_dp_d     = act_dp_q;
        act_blink_d  = act_blink_q;
        act_bz_d     = act_bz_q;
        updated_d    = 1'b0;
        if (load) begin
            pend_val_d   = value;
            pend_dp_d    = dpMask;
            pend_blink_d = blinkMask;
            pend_bz_d    = blankZeros;
            pend_valid_d = 1'b1;
        end
        // A load on the boundary cycle bypasses the pending buffer.
        if (boundary) begin
            if (load) begin
                act_val_d   = value;
                act_dp_d    = dpMask;
                act_blink_d = blinkMask;
                act_bz_d    = blankZeros;
                updated_d   = 1'b1;
            end else if (pend_valid_q) begin
                act_val_d   = pend_val_q;
                act_dp_d    = pend_dp_q;
                act_blink_d = pend_blink_q;
                act_bz_d    = pend_bz_q;
                updated_d   = 1'b1;
            end
            pend_valid_d = 1'b0;
        end
    end

    // Outputs are computed from next-state so the registered pins match the slot position.
    logic [DIGITS-1:0] lz;
    logic              zero_run;
    logic [3:0]        nib;
    logic              sup;

    always_comb begin
        lz       = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (act_val_d[4*i +: 4] == 4'h0);
            lz[i]    = act_bz_d && zero_run;
        end
        nib   = act_val_d[{digit_d, 2'b00} +: 4];
        sup   = (phase_d && act_blink_d[digit_d]) || lz[digit_d];
        an_d  = '1;
        seg_d = 8'hFF;
        if (state_d == StDrive && !sup) begin
            an_d[digit_d] = 1'b0;
            seg_d         = {~act_dp_d[digit_d], ~hex_pattern(nib)};
        end
    end

    assign updated = updated_q;
    assign an      = an_q;
    assign seg     = seg_q;

endmodule
